// File: rtl/cache_pkg.sv
// Shared constants, FSM state type and address-field helpers for the data cache.
package cache_pkg;

  localparam int unsigned ADDR_W      = 10;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned INDEX_W     = 5;
  localparam int unsigned OFFSET_W    = 2;
  localparam int unsigned TAG_W       = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned BLOCK_W     = ADDR_W - OFFSET_W;
  localparam int unsigned MEM_LATENCY = 4;
  localparam int unsigned LINES       = 1 << INDEX_W;
  localparam int unsigned WORDS       = 1 << OFFSET_W;
  localparam int unsigned MEM_DEPTH   = 1 << ADDR_W;

  typedef enum logic [1:0] {StIdle, StFill, StWriteMem} state_e;

  typedef logic [WORDS-1:0][DATA_W-1:0] block_t;

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] get_offset(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W-1:0];
  endfunction

  // Block number = tag and index together, i.e. the word address without the offset.
  function automatic logic [BLOCK_W-1:0] get_block(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:OFFSET_W];
  endfunction

endpackage

// File: rtl/cache_if.sv
// CPU-side request/response bus of the data cache.
interface cache_if;
  import cache_pkg::*;

  logic              Mem_Write;
  logic              Mem_Read;
  logic [ADDR_W-1:0] Word_address;
  logic [DATA_W-1:0] Data_In;
  logic              stall;
  logic [DATA_W-1:0] Data_Out;

  modport master (
    output Mem_Write, Mem_Read, Word_address, Data_In,
    input  stall, Data_Out
  );

  modport slave (
    input  Mem_Write, Mem_Read, Word_address, Data_In,
    output stall, Data_Out
  );
endinterface

// File: rtl/cache_main_memory.sv
// 1024x32 backing memory with a fixed access latency: block reads and single-word writes.
module cache_main_memory
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_done,
  output block_t            o_block
);

  localparam int unsigned CntW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];
  logic              r_busy;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CntW-1:0]   r_cnt;

  // Done is high during the last cycle of an access; the write lands on the edge that ends it.
  assign o_done = r_busy && (r_cnt == '0);

  // Latch the access and count down its latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_we    <= i_we;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
      r_cnt   <= CntW'(MEM_LATENCY - 1);
    end else if (o_done) begin
      r_busy <= 1'b0;
    end else if (r_busy) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Storage: cleared by reset, written at the end of a write access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (o_done && r_we) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  // Whole block around the latched address, consumed by the cache on fill completion.
  always_comb begin
    o_block = '0;
    for (int unsigned w = 0; w < WORDS; w++) begin
      o_block[w] = r_mem[{get_block(r_addr), w[OFFSET_W-1:0]}];
    end
  end

endmodule

// File: rtl/cache_memory_top.sv
// Direct-mapped, write-through, no-write-allocate data cache plus its main memory.
// Optional build macro CACHE_STATS_EN adds saturating read hit/miss counters.
module cache_memory_top
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  cache_if.slave      cpu
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tags [LINES];
  block_t            r_data [LINES];
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_dout;
  state_e            r_state;
  state_e            w_state_next;

  logic [INDEX_W-1:0]  w_index;
  logic [OFFSET_W-1:0] w_offset;
  logic                w_hit;
  logic                w_accept_wr;
  logic                w_accept_rd;
  logic                w_mem_start;
  logic                w_mem_done;
  logic                w_fill_done;
  block_t              w_block;

  assign w_index  = get_index(cpu.Word_address);
  assign w_offset = get_offset(cpu.Word_address);
  assign w_hit    = r_valid[w_index] && (r_tags[w_index] == get_tag(cpu.Word_address));

  // Write wins when both strobes are set; requests are only looked at in idle.
  assign w_accept_wr = (r_state == StIdle) && cpu.Mem_Write;
  assign w_accept_rd = (r_state == StIdle) && cpu.Mem_Read && !cpu.Mem_Write;
  assign w_fill_done = (r_state == StFill) && w_mem_done;

  cache_main_memory u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_mem_start),
    .i_we    (cpu.Mem_Write),
    .i_addr  (cpu.Word_address),
    .i_wdata (cpu.Data_In),
    .o_done  (w_mem_done),
    .o_block (w_block)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= StIdle;
    else      r_state <= w_state_next;
  end

  // FSM next state.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept_wr)                w_state_next = StWriteMem;
        else if (w_accept_rd && !w_hit) w_state_next = StFill;
      end
      StFill:     if (w_mem_done) w_state_next = StIdle;
      StWriteMem: if (w_mem_done) w_state_next = StIdle;
      default:    w_state_next = StIdle;
    endcase
  end

  // FSM outputs: stall while memory is busy, memory kicked off by writes and read misses.
  always_comb begin
    cpu.stall   = (r_state != StIdle);
    w_mem_start = w_accept_wr || (w_accept_rd && !w_hit);
  end

  // Valid bits and the latched request address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_addr  <= '0;
    end else begin
      if (w_accept_wr || w_accept_rd) r_addr <= cpu.Word_address;
      if (w_fill_done)                r_valid[get_index(r_addr)] <= 1'b1;
    end
  end

  // Tag and data arrays: write hits update one word, a fill replaces the whole line.
  always_ff @(posedge clk) begin
    if (w_accept_wr && w_hit) begin
      r_data[w_index][w_offset] <= cpu.Data_In;
    end
    if (w_fill_done) begin
      r_data[get_index(r_addr)] <= w_block;
      r_tags[get_index(r_addr)] <= get_tag(r_addr);
    end
  end

  // Registered read data; holds across writes, idle cycles and stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       r_dout <= '0;
    else if (w_accept_rd && w_hit)  r_dout <= r_data[w_index][w_offset];
    else if (w_fill_done)           r_dout <= w_block[get_offset(r_addr)];
  end

  assign cpu.Data_Out = r_dout;

`ifdef CACHE_STATS_EN
  logic [15:0] r_hits;
  logic [15:0] r_misses;

  // Saturating counters of accepted read hits and misses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else if (w_accept_rd) begin
      if (w_hit && (r_hits != 16'hFFFF))    r_hits   <= r_hits + 1'b1;
      if (!w_hit && (r_misses != 16'hFFFF)) r_misses <= r_misses + 1'b1;
    end
  end

  assign hit_count  = r_hits;
  assign miss_count = r_misses;
`endif

endmodule

// File: tb/tb_cache_memory_top.sv
// Self-checking bench for cache_memory_top: directed scenarios then random traffic,
// checked against an address-level model (memory image plus per-line valid/tag).
module tb_cache_memory_top;
  import cache_pkg::*;

  localparam int Lat = MEM_LATENCY;

  logic clk = 1'b0;
  logic rst = 1'b0;
  cache_if bus ();

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  cache_memory_top dut (
    .clk        (clk),
    .rst        (rst),
    .cpu        (bus.slave)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [31:0] m_mem   [1024];
  bit          m_valid [32];
  logic [2:0]  m_tag   [32];
  logic [31:0] m_dout;
  int          m_hits;
  int          m_misses;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) m_mem[i] = '0;
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
    end
    m_dout   = '0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic drive_idle();
    bus.Mem_Write    = 1'b0;
    bus.Mem_Read     = 1'b0;
    bus.Word_address = '0;
    bus.Data_In      = '0;
  endtask

  // One request; with hold=1 random junk is kept on the bus during the stall and must be ignored.
  task automatic req(input string name, input bit we, input bit re, input logic [9:0] a,
                     input logic [31:0] d, input bit hold);
    int          n;
    int          exp_lat;
    bit          hit;
    logic [31:0] prev_dout;
    logic [4:0]  ix;

    @(negedge clk);
    bus.Mem_Write    = we;
    bus.Mem_Read     = re;
    bus.Word_address = a;
    bus.Data_In      = d;

    ix        = a[6:2];
    hit       = m_valid[ix] && (m_tag[ix] == a[9:7]);
    prev_dout = m_dout;
    if (we) begin
      m_mem[a] = d;
      exp_lat  = Lat;
    end else if (re) begin
      m_dout = m_mem[a];
      if (hit) begin
        exp_lat = 0;
        m_hits++;
      end else begin
        exp_lat    = Lat;
        m_valid[ix] = 1'b1;
        m_tag[ix]   = a[9:7];
        m_misses++;
      end
    end else begin
      exp_lat = 0;
    end

    @(posedge clk);
    #1;
    if (hold) begin
      bus.Mem_Write    = 1'($urandom);
      bus.Mem_Read     = 1'($urandom);
      bus.Word_address = 10'($urandom);
      bus.Data_In      = $urandom;
    end else begin
      drive_idle();
    end
    if (exp_lat > 0) begin
      check({name, ".stall_rise"}, 32'(bus.stall), 32'd1);
      check({name, ".dout_hold"}, bus.Data_Out, prev_dout);
    end
    n = 0;
    while (bus.stall === 1'b1 && n < Lat + 4) begin
      @(posedge clk);
      #1;
      n++;
    end
    drive_idle();
    check({name, ".stall_cycles"}, 32'(n), 32'(exp_lat));
    check({name, ".dout"}, bus.Data_Out, m_dout);
  endtask

  task automatic check_stats(input string name);
`ifdef CACHE_STATS_EN
    check({name, ".hits"}, 32'(hit_count), 32'(m_hits));
    check({name, ".misses"}, 32'(miss_count), 32'(m_misses));
`else
    checks = checks + 0;
`endif
  endtask

  initial begin
    logic [9:0]  a;
    logic [31:0] d;
    int          op;

    drive_idle();
    model_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.stall", 32'(bus.stall), 32'd0);
    check("reset.dout", bus.Data_Out, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed sequence on line 2, tag 111
    req("rd_cold",  1'b0, 1'b1, 10'b111_00010_00, 32'd0,  1'b0);
    req("wr_01",    1'b1, 1'b0, 10'b111_00010_01, 32'd16, 1'b0);
    req("wr_10",    1'b1, 1'b0, 10'b111_00010_10, 32'd8,  1'b1);
    req("wr_00",    1'b1, 1'b0, 10'b111_00010_00, 32'd4,  1'b0);
    req("wr_11",    1'b1, 1'b0, 10'b111_00010_11, 32'd2,  1'b0);
    req("rd_11",    1'b0, 1'b1, 10'b111_00010_11, 32'd0,  1'b0);
    req("rd_10",    1'b0, 1'b1, 10'b111_00010_10, 32'd0,  1'b0);
    req("rd_01",    1'b0, 1'b1, 10'b111_00010_01, 32'd0,  1'b0);
    req("rd_00",    1'b0, 1'b1, 10'b111_00010_00, 32'd0,  1'b0);
    req("wr_hit01", 1'b1, 1'b0, 10'b111_00010_01, 32'd100, 1'b0);
    req("wr_hit10", 1'b1, 1'b0, 10'b111_00010_10, 32'd120, 1'b0);
    for (int i = 0; i < 4; i++) begin
      a = {3'b111, 5'b00010, 2'(i)};
      req("rd_after_hits", 1'b0, 1'b1, a, 32'd0, 1'b0);
    end
    // Tag conflict: write miss leaves the line, read miss replaces it
    req("wr_conflict", 1'b1, 1'b0, 10'b101_00010_01, 32'd200, 1'b0);
    req("rd_101_00",   1'b0, 1'b1, 10'b101_00010_00, 32'd0,   1'b1);
    req("rd_101_01",   1'b0, 1'b1, 10'b101_00010_01, 32'd0,   1'b0);
    req("rd_111_11",   1'b0, 1'b1, 10'b111_00010_11, 32'd0,   1'b0);
    req("rd_111_01",   1'b0, 1'b1, 10'b111_00010_01, 32'd0,   1'b0);
    // Both strobes: write wins
    req("rw_both",     1'b1, 1'b1, 10'b000_00110_01, 32'd60,  1'b0);
    req("rd_both",     1'b0, 1'b1, 10'b000_00110_01, 32'd0,   1'b0);
    check_stats("stats_directed");

    // Random traffic over two indices and all tags to mix hits, misses and conflicts
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 4));
      a  = {3'($urandom), (($urandom_range(0, 1) == 0) ? 5'd3 : 5'd9), 2'($urandom)};
      d  = $urandom;
      req("rand", (op == 0 || op == 2), (op == 1 || op == 2 || op == 3), a, d,
          1'($urandom));
    end
    check_stats("stats_random");

    // Reset in the middle of a memory write
    @(negedge clk);
    bus.Mem_Write    = 1'b1;
    bus.Word_address = 10'b000_00110_01;
    bus.Data_In      = 32'h55;
    @(posedge clk);
    #1;
    drive_idle();
    @(posedge clk);
    #1;
    check("midrst.stall_before", 32'(bus.stall), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst.stall", 32'(bus.stall), 32'd0);
    check("midrst.dout", bus.Data_Out, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    check_stats("stats_after_reset");
    req("rd_after_rst", 1'b0, 1'b1, 10'b000_00110_01, 32'd0, 1'b0);
    req("rd_after_rst2", 1'b0, 1'b1, 10'b111_00010_01, 32'd0, 1'b0);
    check_stats("stats_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
